// File: rtl/dbus_mem_responder.sv
// Data-bus memory responder: accepts one load/store at a time, applies byte-strobed
// writes to a 64-bit word array and answers with the post-write word after LATENCY cycles.
module dbus_mem_responder #(
  parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_data,
  output logic        resp_err
);
  localparam int          IW       = $clog2(DEPTH);
  localparam int          CW       = $clog2(LATENCY + 1);
  localparam logic [63:0] ADDR_END = ADDR_BASE + 64'(DEPTH) * 64'd8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateType;

  stateType        state, stateNext;
  logic [CW-1:0]   counter;
  logic [63:0]     addrQ, dataQ;
  logic [2:0]      sizeQ;
  logic [7:0]      strobeQ;
  logic            enterDone;

  logic [63:0]     accAddr, accData;
  logic [2:0]      accSize;
  logic [7:0]      accStrobe;
  logic            aligned, legal;
  logic [IW-1:0]   wordIdx;
  logic [63:0]     newWord;
  logic [63:0]     mem [DEPTH];

  // NOTE: every output of this block gets a default before the case, so no latch is inferred.
  always_comb begin
    stateNext    = state;
    enterDone    = 1'b0;
    resp_addr_ok = 1'b0;
    unique case (state)
      IDLE: if (req_valid) begin
        resp_addr_ok = 1'b1;
        if (LATENCY == 1) begin
          stateNext = DONE;
          enterDone = 1'b1;
        end else begin
          stateNext = BUSY;
        end
      end
      BUSY: if (counter == CW'(1)) begin
        stateNext = DONE;
        enterDone = 1'b1;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
      addrQ   <= '0;
      sizeQ   <= '0;
      strobeQ <= '0;
      dataQ   <= '0;
    end else begin
      state <= stateNext;
      if (resp_addr_ok) begin
        addrQ   <= req_addr;
        sizeQ   <= req_size;
        strobeQ <= req_strobe;
        dataQ   <= req_data;
        counter <= CW'(LATENCY - 1);
      end else if (state == BUSY) begin
        counter <= counter - CW'(1);
      end
    end
  end

  // With LATENCY==1 the access happens at the accept edge, before the request is latched.
  assign accAddr   = (state == IDLE) ? req_addr   : addrQ;
  assign accSize   = (state == IDLE) ? req_size   : sizeQ;
  assign accStrobe = (state == IDLE) ? req_strobe : strobeQ;
  assign accData   = (state == IDLE) ? req_data   : dataQ;

  always_comb begin
    aligned = 1'b0;
    unique case (accSize)
      3'd0:    aligned = 1'b1;
      3'd1:    aligned = (accAddr[0] == 1'b0);
      3'd2:    aligned = (accAddr[1:0] == 2'b00);
      3'd3:    aligned = (accAddr[2:0] == 3'b000);
      default: aligned = 1'b0;
    endcase
  end

  assign legal   = aligned && (accAddr >= ADDR_BASE) && (accAddr < ADDR_END);
  assign wordIdx = IW'((accAddr - ADDR_BASE) >> 3);

  always_comb begin
    newWord = mem[wordIdx];
    for (int i = 0; i < 8; i++) begin
      if (accStrobe[i]) newWord[8*i +: 8] = accData[8*i +: 8];
    end
  end

  // NOTE: the array is deliberately left out of reset; only the control path is cleared.
  always_ff @(posedge clk) begin
    if (enterDone && legal) mem[wordIdx] <= newWord;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_data_ok <= 1'b0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
    end else begin
      resp_data_ok <= enterDone;
      if (enterDone) begin
        resp_data <= legal ? newWord : 64'd0;
        resp_err  <= !legal;
      end
    end
  end
endmodule

// File: tb/tb_dbus_mem_responder.sv
// Bench for dbus_mem_responder: directed vector table, multi-cycle corner sequences
// and randomized traffic against a byte-lane memory model.
module tb_dbus_mem_responder;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reqValid = 1'b0, reqValid1 = 1'b0;
  logic [63:0] reqAddr = '0, reqAddr1 = '0, reqData = '0, reqData1 = '0;
  logic [2:0]  reqSize = '0, reqSize1 = '0;
  logic [7:0]  reqStrobe = '0, reqStrobe1 = '0;
  logic        addrOk, dataOk, err, addrOk1, dataOk1, err1;
  logic [63:0] rdata, rdata1;

  int cyc = 0;
  int nCompared = 0;
  int nMismatched = 0;
  logic [63:0] model [16];

  dbus_mem_responder #(.ADDR_BASE(BASE), .DEPTH(1024), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(reqValid), .req_addr(reqAddr), .req_size(reqSize),
    .req_strobe(reqStrobe), .req_data(reqData), .resp_addr_ok(addrOk), .resp_data_ok(dataOk),
    .resp_data(rdata), .resp_err(err));

  dbus_mem_responder #(.ADDR_BASE(BASE), .DEPTH(16), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(reqValid1), .req_addr(reqAddr1), .req_size(reqSize1),
    .req_strobe(reqStrobe1), .req_data(reqData1), .resp_addr_ok(addrOk1), .resp_data_ok(dataOk1),
    .resp_data(rdata1), .resp_err(err1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, want finish before 500us");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // sel: 0=addrOk 1=dataOk (latency-2 unit), 2=addrOk1 3=dataOk1 (latency-1 unit)
  task automatic waitSig(input int sel, output int t);
    t = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if ((sel == 0 && addrOk) || (sel == 1 && dataOk) ||
          (sel == 2 && addrOk1) || (sel == 3 && dataOk1)) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check($sformatf("wait%0d.timeout", sel), 64'd0, 64'd1);
  endtask

  task automatic runReq(input logic [63:0] a, input logic [2:0] s, input logic [7:0] st,
                        input logic [63:0] d, output logic [63:0] rd, output logic re,
                        output int lat);
    int tA, tD;
    rd = 'x; re = 1'bx; lat = -1;
    reqValid = 1'b1; reqAddr = a; reqSize = s; reqStrobe = st; reqData = d;
    waitSig(0, tA);
    if (tA >= 0) begin
      waitSig(1, tD);
      if (tD >= 0) begin
        rd = rdata; re = err; lat = tD - tA;
      end
    end
    reqValid = 1'b0;
  endtask

  // Reference: legality from the address rules, then byte-lane merge into the word model.
  function automatic void modelAccess(input logic [63:0] a, input logic [2:0] s,
                                      input logic [7:0] st, input logic [63:0] d,
                                      output logic [63:0] ed, output logic ee);
    bit ok;
    int idx;
    ok = (s <= 3) && (a >= BASE) && (a < BASE + 64'd8192);
    if (ok) ok = (a % (64'd1 << s)) == 0;
    if (!ok) begin
      ed = 64'd0; ee = 1'b1;
    end else begin
      idx = int'((a - BASE) / 8);
      for (int b = 0; b < 8; b++)
        if (st[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      ed = model[idx]; ee = 1'b0;
    end
  endfunction

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [63:0] expData;
    logic        expErr;
  } vecType;

  initial begin
    vecType vecs[$];
    logic [63:0] rd, ed, a, d;
    logic re, ee;
    logic [2:0] s;
    logic [7:0] st;
    int lat, tA, tD, tA2, seenOk;

    vecs = '{
      '{BASE + 64'h0000, 3'd3, 8'hFF, 64'hA5A5_0000_5A5A_FFFF, 64'hA5A5_0000_5A5A_FFFF, 1'b0},
      '{BASE + 64'h0008, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 1'b0},
      '{BASE + 64'h0008, 3'd3, 8'h00, 64'h0,                   64'h1122_3344_5566_7788, 1'b0},
      '{BASE + 64'h0008, 3'd0, 8'h04, 64'h0000_0000_00AB_0000, 64'h1122_3344_55AB_7788, 1'b0},
      '{BASE + 64'h0008, 3'd3, 8'h00, 64'h0,                   64'h1122_3344_55AB_7788, 1'b0},
      '{BASE + 64'h0002, 3'd2, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0,                   1'b1},
      '{BASE + 64'h2000, 3'd3, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0,                   1'b1},
      '{BASE - 64'h0008, 3'd3, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0,                   1'b1},
      '{BASE + 64'h0000, 3'd4, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0,                   1'b1},
      '{BASE + 64'h0000, 3'd7, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0,                   1'b1},
      '{BASE + 64'h0000, 3'd3, 8'h00, 64'h0,                   64'hA5A5_0000_5A5A_FFFF, 1'b0},
      '{BASE + 64'h1FF8, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0},
      '{BASE + 64'h1FFE, 3'd1, 8'hC0, 64'hBEEF_0000_0000_0000, 64'hBEEF_4567_89AB_CDEF, 1'b0},
      '{BASE + 64'h0010, 3'd3, 8'hFF, 64'hCAFE_F00D_1234_5678, 64'hCAFE_F00D_1234_5678, 1'b0},
      '{BASE + 64'h0011, 3'd1, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0,                   1'b1},
      '{BASE + 64'h0014, 3'd2, 8'hF0, 64'h9999_8888_0000_0000, 64'h9999_8888_1234_5678, 1'b0}
    };

    // Power-up reset
    repeat (3) @(negedge clk);
    check("por.addrOk", addrOk, 0);
    check("por.dataOk", dataOk, 0);
    check("por.data", rdata, 0);
    check("por.err", err, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle.noAccept", addrOk, 0);

    foreach (vecs[i]) begin
      runReq(vecs[i].addr, vecs[i].size, vecs[i].strobe, vecs[i].data, rd, re, lat);
      check($sformatf("vec%0d.data", i), rd, vecs[i].expData);
      check($sformatf("vec%0d.err", i), re, vecs[i].expErr);
      check($sformatf("vec%0d.lat", i), lat, 2);
    end
    @(negedge clk);
    check("hold.data", rdata, 64'h9999_8888_1234_5678);
    check("hold.dataOk", dataOk, 0);

    // Back-to-back with req_valid held across data_ok
    reqValid = 1'b1; reqAddr = BASE + 64'h8; reqSize = 3'd3; reqStrobe = 8'h00; reqData = '0;
    waitSig(0, tA);
    waitSig(1, tD);
    check("b2b.lat1", tD - tA, 2);
    check("b2b.data1", rdata, 64'h1122_3344_55AB_7788);
    reqAddr = BASE;
    waitSig(0, tA2);
    check("b2b.gap", tA2 - tD, 1);
    waitSig(1, tD);
    check("b2b.lat2", tD - tA2, 2);
    check("b2b.data2", rdata, 64'hA5A5_0000_5A5A_FFFF);
    reqValid = 1'b0;

    // Reset while BUSY drops a write to word 2
    reqValid = 1'b1; reqAddr = BASE + 64'h10; reqSize = 3'd3; reqStrobe = 8'hFF;
    reqData = 64'h0BAD_0BAD_0BAD_0BAD;
    waitSig(0, tA);
    @(negedge clk);
    reqValid = 1'b0;
    reset = 1'b0;
    #1;
    check("rst.addrOk", addrOk, 0);
    check("rst.dataOk", dataOk, 0);
    check("rst.data", rdata, 0);
    check("rst.err", err, 0);
    seenOk = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (dataOk) seenOk++;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (dataOk) seenOk++;
    end
    check("rst.noDataOk", seenOk, 0);
    check("rst.idleAddrOk", addrOk, 0);
    runReq(BASE + 64'h10, 3'd3, 8'h00, 64'h0, rd, re, lat);
    check("rst.prior", rd, 64'h9999_8888_1234_5678);
    check("rst.priorErr", re, 0);

    // LATENCY=1 unit, req_valid held through three requests
    reqValid1 = 1'b1; reqAddr1 = BASE; reqSize1 = 3'd3; reqStrobe1 = 8'hFF;
    reqData1 = 64'h0F0E_0D0C_0B0A_0908;
    waitSig(2, tA);
    waitSig(3, tD);
    check("l1.lat1", tD - tA, 1);
    check("l1.data1", rdata1, 64'h0F0E_0D0C_0B0A_0908);
    reqStrobe1 = 8'h00;
    waitSig(2, tA);
    check("l1.gap1", tA - tD, 1);
    waitSig(3, tD);
    check("l1.lat2", tD - tA, 1);
    check("l1.data2", rdata1, 64'h0F0E_0D0C_0B0A_0908);
    reqAddr1 = BASE + 64'h80; reqStrobe1 = 8'hFF;
    waitSig(2, tA);
    check("l1.gap2", tA - tD, 1);
    waitSig(3, tD);
    check("l1.lat3", tD - tA, 1);
    check("l1.oorData", rdata1, 0);
    check("l1.oorErr", err1, 1);
    reqValid1 = 1'b0;

    // Randomized traffic over words 0..15 plus illegal addresses and sizes
    for (int w = 0; w < 16; w++) begin
      d = {$urandom, $urandom};
      model[w] = d;
      runReq(BASE + 64'(8 * w), 3'd3, 8'hFF, d, rd, re, lat);
      check($sformatf("init%0d", w), rd, d);
    end
    for (int n = 0; n < 150; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      a = BASE + 64'($urandom_range(0, 127));
      s = 3'($urandom_range(0, 3));
      if (kind == 0)      s = 3'($urandom_range(4, 7));
      else if (kind == 1) a = BASE + 64'h2000 + 64'($urandom_range(0, 127));
      else if (kind == 2) a = BASE - 64'd128 + 64'($urandom_range(0, 127));
      else if (kind <= 6) a = a & ~((64'd1 << s) - 64'd1);
      st = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      d = {$urandom, $urandom};
      modelAccess(a, s, st, d, ed, ee);
      runReq(a, s, st, d, rd, re, lat);
      check($sformatf("rnd%0d.data a=%h s=%0d", n, a, s), rd, ed);
      check($sformatf("rnd%0d.err", n), re, ee);
      check($sformatf("rnd%0d.lat", n), lat, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/dbus_mem_responder.md
Name: dbus_mem_responder

Overview:
- Data-memory responder on the pipeline's data bus: the far end of the load/store interface driven from the memory stage.
- Accepts one request at a time and applies byte-strobed writes to an internal word array.
- Returns the full 64-bit word read at the request address after a programmable latency, with an error flag for illegal accesses.
- Sign/zero extension and byte selection of load data stay in the pipeline.

Parameters:
ADDR_BASE, 64'h8000_0000, byte address of word 0 of the array
DEPTH, 1024, number of 64-bit words (power of two)
LATENCY, 2, cycles from the accept cycle to the data_ok cycle (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
req_valid  input  1  request present; initiator holds it and all req_* stable until resp_data_ok
req_addr  input  64  byte address
req_size  input  3  access size: 0=1B, 1=2B, 2=4B, 3=8B; 4..7 illegal
req_strobe  input  8  byte write enables; 0 = read
req_data  input  64  write data, lane-aligned to the word
resp_addr_ok  output  1  request accepted this cycle
resp_data_ok  output  1  response valid this cycle (one-cycle pulse)
resp_data  output  64  full word read at request address
resp_err  output  1  access was illegal, qualified by resp_data_ok

Behaviour:
- FSM states: IDLE, BUSY, DONE. Latency counter is clog2(LATENCY+1) bits wide.
- Reset (asynchronous assert, any state):
  - state=IDLE, counter=0, resp_data_ok=0, resp_data=0, resp_err=0.
  - Array contents are not reset.
  - A request in flight is dropped with no write.
  - After reset release, the initiator must re-present the request.
- IDLE:
  - resp_addr_ok = req_valid (combinational, only in IDLE).
  - On accept, latch addr/size/strobe/data and load counter = LATENCY-1.
  - Next state is BUSY, or DONE if LATENCY==1.
- BUSY:
  - Decrement the counter each cycle.
  - When counter==1 at the edge, go to DONE.
- Entering DONE:
  - Access is performed at the edge that enters DONE.
  - resp_data_ok=1 and resp_err/resp_data are registered for exactly one cycle.
- resp_data_ok asserts exactly LATENCY cycles after the resp_addr_ok cycle.
- DONE lasts one cycle, then IDLE.
  - A req_valid still high in the first IDLE cycle is treated as a new request; back-to-back throughput is one request per LATENCY+1 cycles.
- Legality:
  - Illegal if req_size>3.
  - Illegal if req_addr is not aligned to 1<<req_size.
  - Illegal if req_addr < ADDR_BASE or req_addr >= ADDR_BASE+8*DEPTH.
  - Illegal access: no array write, resp_data=0, resp_err=1.
- Legal access:
  - index = (req_addr-ADDR_BASE)>>3, taking the low clog2(DEPTH) bits.
  - Each byte lane i with strobe[i]=1 is written from req_data[8i+7:8i].
  - Strobe is not checked against size.
  - resp_data returns the word value after the write (write-first).
  - resp_err=0.
- A request with req_valid low is never accepted.
- req_* changes while not in IDLE are ignored; latched values are used.
- resp_data holds its last value outside data_ok cycles.
  - It becomes 0 only on reset or an error response.

Test Plan:
1. Reset low mid-run, then release → all outputs 0; resp_addr_ok=0 while req_valid=0.
2. LATENCY=2, write 0x8000_0008, size=3, strobe=FF, data=0x1122334455667788 → addr_ok cycle t, data_ok at t+2 with resp_data=0x1122334455667788, err=0. Then read the same address → same data.
3. Partial write 0x8000_0008 size=0 strobe=0x04 data=0x0000_0000_00AB_0000 over the test-2 word → subsequent read returns 0x1122334455AB7788.
4. Misaligned 0x8000_0002 size=2, then out-of-range 0x8000_2000 with DEPTH=1024, strobe=FF → data_ok with err=1, resp_data=0. Array unchanged (verified by a later read).
5. req_valid held high across data_ok with two queued requests → second addr_ok exactly one cycle after first data_ok; LATENCY=1 gives data_ok one cycle after each addr_ok.
6. Reset asserted in BUSY during a write to 0x8000_0010 → no data_ok. A read after re-init returns the prior contents of that word (no write occurred).
